// File: rtl/ntt_pkg.sv
// Shared types for the NTT pipeline: FIFO entry layout, pair-issuer state encoding, default modulus.
package ntt_pkg;

  localparam logic [31:0] DEFAULT_MOD_Q = 32'd8380417;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN_WAIT,
    ST_DONE
  } issuer_state_e;

  // One entry carries two butterflies: four coefficients and two twiddles.
  typedef struct packed {
    logic        valid;
    logic [1:0]  stage;
    logic        is_intt;
    logic [31:0] i;
    logic [31:0] j;
    logic [31:0] current_pair;
    logic [7:0]  m;
    logic [7:0]  counter;
    logic [31:0] mod_q;
    logic [31:0] index1;
    logic [31:0] index2;
    logic [31:0] index3;
    logic [31:0] index4;
    logic [31:0] tf_index1;
    logic [31:0] tf_index2;
    logic [31:0] poly1;
    logic [31:0] poly2;
    logic [31:0] poly3;
    logic [31:0] poly4;
    logic [31:0] tf_val1;
    logic [31:0] tf_val2;
    logic [31:0] btfu_out1;
    logic [31:0] btfu_out2;
    logic        butterfly_done;
    logic [7:0]  butterfly_id;
  } ntt_pipeline_data_t;

endpackage

// File: rtl/ntt_pair_addr_gen.sv
// Combinational address generator: (stage, pair, direction) -> coefficient indices of two
// butterflies, their twiddle indices, group of the first butterfly and half-span len.
module ntt_pair_addr_gen #(
  parameter int N     = 256,
  parameter int LOG_N = $clog2(N),
  parameter int SW    = $clog2(LOG_N),
  parameter int PW    = LOG_N - 2
) (
  input  logic [SW-1:0]    s,
  input  logic [PW-1:0]    p,
  input  logic             is_intt,
  output logic [LOG_N-1:0] index1,
  output logic [LOG_N-1:0] index2,
  output logic [LOG_N-1:0] index3,
  output logic [LOG_N-1:0] index4,
  output logic [LOG_N-1:0] tf_index1,
  output logic [LOG_N-1:0] tf_index2,
  output logic [LOG_N-1:0] g0,
  output logic [LOG_N-1:0] len
);

  logic [SW-1:0]    lsh;
  logic [SW-1:0]    gsh;
  logic [SW:0]      lsh1;
  logic [LOG_N-1:0] mask, grp_cnt;
  logic [LOG_N-1:0] bf0, bf1, g1, k0, k1, a0, a1;

  // len and group count are powers of two, so div/mod collapse to shift/mask.
  always_comb begin
    lsh     = is_intt ? s : SW'(LOG_N - 1) - s;
    lsh1    = {1'b0, lsh} + (SW+1)'(1);
    gsh     = SW'(LOG_N - 1) - lsh;
    len     = LOG_N'(1) << lsh;
    mask    = len - LOG_N'(1);
    grp_cnt = LOG_N'(1) << gsh;
    bf0     = {1'b0, p, 1'b0};
    bf1     = {1'b0, p, 1'b1};
    g0      = bf0 >> lsh;
    g1      = bf1 >> lsh;
    k0      = bf0 & mask;
    k1      = bf1 & mask;
    a0      = (g0 << lsh1) | k0;
    a1      = (g1 << lsh1) | k1;
    index1  = a0;
    index2  = a0 | len;
    index3  = a1;
    index4  = a1 | len;
    // 2G can overflow LOG_N bits at G=N/2; the modular result is still exact.
    tf_index1 = is_intt ? (grp_cnt << 1) - LOG_N'(1) - g0 : grp_cnt + g0;
    tf_index2 = is_intt ? (grp_cnt << 1) - LOG_N'(1) - g1 : grp_cnt + g1;
  end

endmodule

// File: rtl/ntt_pair_issuer.sv
// Write end of the NTT pipeline FIFO: walks all stages of an N-point NTT/INTT, one butterfly pair
// per entry, with stage barriers. NTT_ISSUER_PERF_EN enables stall/drain cycle counters.
module ntt_pair_issuer import ntt_pkg::*; #(
  parameter int          N     = 256,
  parameter int          LOG_N = $clog2(N),
  parameter logic [31:0] MOD_Q = DEFAULT_MOD_Q
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_intt,
  input  logic               drain_done,
  input  logic               fifo_full,
  output logic               fifo_write_en,
  output ntt_pipeline_data_t fifo_write_data,
  output logic               busy,
  output logic               done,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        drain_cycles
);

  localparam int SW = $clog2(LOG_N);
  localparam int PW = LOG_N - 2;
  localparam logic [PW-1:0] LAST_PAIR  = PW'(N/4 - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);

  issuer_state_e      state, state_nx;
  logic [SW-1:0]      stage_q, s_ld;
  logic [PW-1:0]      pair_q, p_ld;
  logic               intt_q, intt_ld;
  logic [7:0]         cnt_q, cnt_ld;
  logic               load, last_pair, last_stage;
  logic [LOG_N-1:0]   ag_idx1, ag_idx2, ag_idx3, ag_idx4, ag_tf1, ag_tf2, ag_g0, ag_len;
  ntt_pipeline_data_t entry;

  assign last_pair  = (pair_q == LAST_PAIR);
  assign last_stage = (stage_q == LAST_STAGE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:       if (start) state_nx = ST_ISSUE;
      ST_ISSUE:      if (fifo_write_en && last_pair) state_nx = ST_DRAIN_WAIT;
      ST_DRAIN_WAIT: if (drain_done) state_nx = last_stage ? ST_DONE : ST_ISSUE;
      ST_DONE:       state_nx = ST_IDLE;
      default:       state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_write_en = (state == ST_ISSUE) && !fifo_full;
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
  end

  // Next walk position; the entry register loads the entry for this position on state entry
  // or when the presented entry is accepted, so data holds still under back-pressure.
  always_comb begin
    load    = 1'b0;
    s_ld    = stage_q;
    p_ld    = pair_q;
    intt_ld = intt_q;
    cnt_ld  = cnt_q;
    case (state)
      ST_IDLE: if (start) begin
        load    = 1'b1;
        s_ld    = '0;
        p_ld    = '0;
        intt_ld = is_intt;
        cnt_ld  = '0;
      end
      ST_ISSUE: if (fifo_write_en) begin
        cnt_ld = cnt_q + 8'd1;
        if (!last_pair) begin
          load = 1'b1;
          p_ld = pair_q + PW'(1);
        end
      end
      ST_DRAIN_WAIT: if (drain_done && !last_stage) begin
        load = 1'b1;
        s_ld = stage_q + SW'(1);
        p_ld = '0;
      end
      default: ;
    endcase
  end

  ntt_pair_addr_gen #(.N(N), .LOG_N(LOG_N), .SW(SW), .PW(PW)) u_addr (
    .s         (s_ld),
    .p         (p_ld),
    .is_intt   (intt_ld),
    .index1    (ag_idx1),
    .index2    (ag_idx2),
    .index3    (ag_idx3),
    .index4    (ag_idx4),
    .tf_index1 (ag_tf1),
    .tf_index2 (ag_tf2),
    .g0        (ag_g0),
    .len       (ag_len)
  );

  always_comb begin
    entry              = '0;
    entry.valid        = 1'b1;
    entry.stage        = 2'b00;
    entry.is_intt      = intt_ld;
    entry.i            = 32'(s_ld);
    entry.j            = 32'(ag_g0);
    entry.current_pair = 32'(p_ld);
    entry.m            = 8'(ag_len);
    entry.counter      = cnt_ld;
    entry.mod_q        = MOD_Q;
    entry.index1       = 32'(ag_idx1);
    entry.index2       = 32'(ag_idx2);
    entry.index3       = 32'(ag_idx3);
    entry.index4       = 32'(ag_idx4);
    entry.tf_index1    = 32'(ag_tf1);
    entry.tf_index2    = 32'(ag_tf2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q         <= '0;
      pair_q          <= '0;
      intt_q          <= 1'b0;
      cnt_q           <= '0;
      fifo_write_data <= '0;
    end else begin
      stage_q <= s_ld;
      pair_q  <= p_ld;
      intt_q  <= intt_ld;
      cnt_q   <= cnt_ld;
      if (load) fifo_write_data <= entry;
    end
  end

`ifdef NTT_ISSUER_PERF_EN
  logic [31:0] stall_q, drain_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      drain_q <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      if (state == ST_ISSUE && fifo_full && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
      if (state == ST_DRAIN_WAIT && drain_q != 32'hFFFF_FFFF)        drain_q <= drain_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign drain_cycles = drain_q;
`else
  assign stall_cycles = '0;
  assign drain_cycles = '0;
`endif

endmodule

// File: tb/tb_ntt_pair_issuer.sv
// Bench for ntt_pair_issuer at N=16: spec-arithmetic reference queue, drain responder, directed
// stall/barrier/reset scenarios plus randomized back-pressure runs.
`timescale 1ns/1ps
module tb_ntt_pair_issuer;
  import ntt_pkg::*;

  localparam int N = 16, LOG_N = 4, PAIRS = N/4, TOTAL = LOG_N*PAIRS;
  localparam int DW = $bits(ntt_pipeline_data_t);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_intt = 1'b0, drain_done = 1'b0, fifo_full = 1'b0;
  logic fifo_write_en, busy, done;
  ntt_pipeline_data_t fifo_write_data;
  logic [31:0] stall_cycles, drain_cycles;

  ntt_pair_issuer #(.N(N)) dut (
    .clk(clk), .reset(rst), .start(start), .is_intt(is_intt), .drain_done(drain_done),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .busy(busy), .done(done), .stall_cycles(stall_cycles), .drain_cycles(drain_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: direct arithmetic from the schedule rules.
  function automatic ntt_pipeline_data_t ref_entry(input bit intt, input int s, input int p, input int idx);
    ntt_pipeline_data_t e;
    int len, grp, b, g, k, a, tf;
    e   = '0;
    len = intt ? (1 << s) : (N >> (s + 1));
    grp = N / (2 * len);
    for (int h = 0; h < 2; h++) begin
      b  = 2*p + h;
      g  = b / len;
      k  = b % len;
      a  = 2*len*g + k;
      tf = intt ? (2*grp - 1 - g) : (grp + g);
      if (h == 0) begin
        e.index1 = 32'(a); e.index2 = 32'(a + len); e.tf_index1 = 32'(tf); e.j = 32'(g);
      end else begin
        e.index3 = 32'(a); e.index4 = 32'(a + len); e.tf_index2 = 32'(tf);
      end
    end
    e.valid = 1'b1; e.is_intt = intt; e.i = 32'(s); e.current_pair = 32'(p);
    e.m = 8'(len); e.counter = 8'(idx % 256); e.mod_q = 32'd8380417;
    return e;
  endfunction

  ntt_pipeline_data_t exp_q[$];
  ntt_pipeline_data_t s3p0, snap;
  int  wr_total = 0, stage_wr = 0, stage_cnt = 0, drain_lat = 0, wait_cnt = 0, done_cnt = 0;
  bit  draining = 0, post_chk = 0, post_last = 0;

  // Monitor + drain responder, all on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      draining = 0; post_chk = 0; drain_done = 1'b0; stage_wr = 0; stage_cnt = 0;
      continue;
    end
    if (post_chk) begin
      chk("done_after_drain", DW'(done), DW'(post_last));
      if (!fifo_full) chk("issue_after_drain", DW'(fifo_write_en), DW'(!post_last));
      post_chk = 0;
    end
    drain_done = 1'b0;
    if (fifo_full) chk("we_under_full", DW'(fifo_write_en), DW'(0));
    if (draining)  chk("quiet_in_drain", DW'(fifo_write_en), DW'(0));
    if (done) begin
      done_cnt++;
      chk("busy_with_done", DW'(busy), DW'(1));
    end
    if (fifo_write_en) begin
      if (wr_total == 12) s3p0 = fifo_write_data;
      chk("write_expected", DW'(fifo_write_en), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk($sformatf("entry%0d", wr_total), fifo_write_data, exp_q.pop_front());
      wr_total++;
      stage_wr++;
      if (stage_wr == PAIRS) begin
        stage_wr = 0; draining = 1; wait_cnt = drain_lat;
      end
    end else if (draining) begin
      if (wait_cnt == 0) begin
        drain_done = 1'b1; draining = 0; stage_cnt++;
        post_chk = 1; post_last = (stage_cnt == LOG_N);
      end else wait_cnt--;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_run(input bit intt);
    int idx = 0;
    exp_q.delete();
    for (int s = 0; s < LOG_N; s++)
      for (int p = 0; p < PAIRS; p++) begin
        exp_q.push_back(ref_entry(intt, s, p, idx));
        idx++;
      end
    wr_total = 0; done_cnt = 0; stage_wr = 0; stage_cnt = 0;
    fifo_full = 1'b0; start = 1'b1; is_intt = intt;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", DW'(busy), DW'(1));
    chk("first_write_latency", DW'(fifo_write_en), DW'(1));
  endtask

  task automatic wait_done(input int budget, input bit rand_full, input bit poke);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      tick(); cyc++;
      if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
      if (poke && cyc == 5) begin start = 1'b1; is_intt = ~is_intt; end
      else start = 1'b0;
    end
    fifo_full = 1'b0; start = 1'b0;
    chk("done_within_budget", DW'(done_cnt != 0), DW'(1));
    @(negedge clk);
    chk("idle_after_done", DW'(busy), DW'(0));
    chk("done_once", DW'(done_cnt), DW'(1));
    chk("all_written", DW'(wr_total), DW'(TOTAL));
    chk("model_drained", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    int cyc;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_we", DW'(fifo_write_en), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_data", fifo_write_data, DW'(0));
    chk("rst_stall", DW'(stall_cycles), DW'(0));
    chk("rst_drain", DW'(drain_cycles), DW'(0));
    tick(); rst = 1'b0; tick();

    // forward NTT, never full
    begin_run(1'b0);
    chk("ntt_s0p0_idx", DW'({fifo_write_data.index1, fifo_write_data.index2, fifo_write_data.index3,
        fifo_write_data.index4}), DW'({32'd0, 32'd8, 32'd1, 32'd9}));
    chk("ntt_s0p0_tf", DW'({fifo_write_data.tf_index1, fifo_write_data.tf_index2}), DW'({32'd1, 32'd1}));
    chk("ntt_s0p0_m", DW'(fifo_write_data.m), DW'(8'd8));
    wait_done(200, 1'b0, 1'b0);

    // inverse NTT
    begin_run(1'b1);
    chk("intt_s0p0_idx", DW'({fifo_write_data.index1, fifo_write_data.index2, fifo_write_data.index3,
        fifo_write_data.index4}), DW'({32'd0, 32'd1, 32'd2, 32'd3}));
    chk("intt_s0p0_tf", DW'({fifo_write_data.tf_index1, fifo_write_data.tf_index2}), DW'({32'd15, 32'd14}));
    chk("intt_s0p0_j", DW'(fifo_write_data.j), DW'(0));
    wait_done(200, 1'b0, 1'b0);
    chk("intt_s3p0_idx", DW'({s3p0.index1, s3p0.index2, s3p0.index3, s3p0.index4}),
        DW'({32'd0, 32'd8, 32'd1, 32'd9}));
    chk("intt_s3p0_tf", DW'({s3p0.tf_index1, s3p0.tf_index2}), DW'({32'd1, 32'd1}));

    // back-pressure while pair 2 is presented
    begin_run(1'b0);
    cyc = 0;
    while (wr_total != 2 && cyc < 50) begin tick(); cyc++; end
    fifo_full = 1'b1;
    snap = fifo_write_data;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_we", DW'(fifo_write_en), DW'(0));
      chk("stall_pair", DW'(fifo_write_data.current_pair), DW'(2));
      chk("stall_hold", fifo_write_data, snap);
      tick();
    end
    fifo_full = 1'b0;
    wait_done(200, 1'b0, 1'b0);
`ifdef NTT_ISSUER_PERF_EN
    chk("stall_cycles", DW'(stall_cycles), DW'(3));
`else
    chk("stall_cycles_off", DW'(stall_cycles), DW'(0));
`endif

    // withheld drain_done, plus a start pulse while busy
    drain_lat = 10;
    begin_run(1'b0);
    wait_done(400, 1'b0, 1'b1);
    drain_lat = 0;
`ifdef NTT_ISSUER_PERF_EN
    chk("drain_cycles_min", DW'(drain_cycles >= 32'd10), DW'(1));
`else
    chk("drain_cycles_off", DW'(drain_cycles), DW'(0));
`endif

    // randomized back-pressure and drain latency
    for (int r = 0; r < 4; r++) begin
      drain_lat = $urandom_range(0, 3);
      begin_run(r[0]);
      wait_done(600, 1'b1, r == 1);
    end
    drain_lat = 0;

    // async reset in the middle of stage 2, then a clean replay
    begin_run(1'b1);
    cyc = 0;
    while (wr_total < 9 && cyc < 100) begin tick(); cyc++; end
    chk("reached_stage2", DW'(wr_total >= 9), DW'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", DW'(fifo_write_en), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_done", DW'(done), DW'(0));
    chk("mid_rst_data", fifo_write_data, DW'(0));
    @(negedge clk);
    tick(); rst = 1'b0; tick();
    begin_run(1'b0);
    chk("replay_counter", DW'(fifo_write_data.counter), DW'(0));
    chk("replay_stage", DW'(fifo_write_data.i), DW'(0));
    wait_done(600, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
